// File: rtl/iadc_conv_sequencer_if.sv
// Sequencer-side bundle: host start/continuous controls, filter reset/data, result valid/ready and status flags.
// master = sequencer view, slave = host/filter view.
interface iadc_conv_sequencer_if #(
  parameter int DW = 12
);
  logic          start;
  logic          cont;
  logic          filt_rst_n;
  logic          mod_rst;
  logic [DW-1:0] filt_data;
  logic          filt_new_data;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic          overrun;
  logic          timeout;

  modport master (
    input  start, cont, filt_data, filt_new_data, result_ready,
    output filt_rst_n, mod_rst, result, result_valid, busy, overrun, timeout
  );

  modport slave (
    output start, cont, filt_data, filt_new_data, result_ready,
    input  filt_rst_n, mod_rst, result, result_valid, busy, overrun, timeout
  );
endinterface

// File: rtl/iadc_conv_sequencer.sv
// Incremental-ADC conversion sequencer: reset -> OSR-clock convert -> wait for filter strobe -> capture.
// Macro IADC_SEQ_CONTINUOUS_EN enables back-to-back conversions via cont; all outputs registered.
module iadc_conv_sequencer #(
  parameter int OSR        = 512,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 8,
  parameter int DW         = 12
) (
  input logic                   clk,
  input logic                   rst,
  iadc_conv_sequencer_if.master bus
);

  localparam int MAX_RT = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int MAXC   = (OSR > MAX_RT) ? OSR : MAX_RT;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] OSR_LD = CW'(OSR - 1);
  localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_CONVERT, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          capture, tmo_hit, cont_go;

  logic          filt_rst_n_q, mod_rst_q, busy_q;
  logic          result_valid_q, overrun_q, timeout_q;
  logic [DW-1:0] result_q;

`ifdef IADC_SEQ_CONTINUOUS_EN
  assign cont_go = bus.cont;
`else
  logic unused_cont;
  assign unused_cont = bus.cont;
  assign cont_go     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_RESET;
          cnt_nxt   = RST_LD;
        end
      end
      S_RESET: begin
        if (cnt == '0) begin
          state_nxt = S_CONVERT;
          cnt_nxt   = OSR_LD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_CONVERT: begin
        if (cnt == '0) begin
          state_nxt = S_WAIT;
          cnt_nxt   = TMO_LD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_WAIT: begin
        if (bus.filt_new_data) begin
          capture   = 1'b1;
          state_nxt = cont_go ? S_RESET : S_IDLE;
          cnt_nxt   = RST_LD;
        end else if (cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      filt_rst_n_q   <= 1'b0;
      mod_rst_q      <= 1'b1;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      filt_rst_n_q <= (state_nxt == S_CONVERT) || (state_nxt == S_WAIT);
      mod_rst_q    <= !((state_nxt == S_CONVERT) || (state_nxt == S_WAIT));
      busy_q       <= (state_nxt != S_IDLE);
      if (tmo_hit) timeout_q <= 1'b1;
      if (capture) begin
        result_q       <= bus.filt_data;
        result_valid_q <= 1'b1;
        if (result_valid_q && !bus.result_ready) overrun_q <= 1'b1;
      end else if (result_valid_q && bus.result_ready) begin
        result_valid_q <= 1'b0;
      end
    end
  end

  assign bus.filt_rst_n   = filt_rst_n_q;
  assign bus.mod_rst      = mod_rst_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_iadc_conv_sequencer.sv
// Directed bench for iadc_conv_sequencer: cycle-exact control checks plus a result scoreboard
// fed at each strobe and drained by an independent monitor.
module tb_iadc_conv_sequencer;
  localparam int OSR = 512;
  localparam int RC  = 2;
  localparam int TO  = 8;
  localparam int DW  = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iadc_conv_sequencer_if #(.DW(DW)) bus();

  iadc_conv_sequencer #(.OSR(OSR), .RST_CYCLES(RC), .TIMEOUT(TO), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after E0, the edge that samples start.
  task automatic do_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  // Strobe is sampled at the next edge; returns just after that edge.
  task automatic strobe(input logic [DW-1:0] d, input logic rdy);
    bus.filt_data     = d;
    bus.filt_new_data = 1'b1;
    bus.result_ready  = rdy;
    exp_q.push_back(d);
    step(1);
    bus.filt_new_data = 1'b0;
    bus.result_ready  = 1'b0;
  endtask

  task automatic ack();
    bus.result_ready = 1'b1;
    step(1);
    bus.result_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_filt_rst_n"}, bus.filt_rst_n, 0);
    chk({tag, "_mod_rst"}, bus.mod_rst, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_result"}, bus.result, 0);
    chk({tag, "_result_valid"}, bus.result_valid, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
  endtask

  // Monitor: every new result presentation (valid rising, or value replaced while valid) pops one expectation.
  logic          pv = 1'b0;
  logic [DW-1:0] pr = '0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pr = '0;
    end else begin
      if (bus.result_valid && (!pv || bus.result !== pr)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got 0x%0h, none expected", bus.result);
        end else begin
          chk("sb_result", bus.result, exp_q.pop_front());
        end
      end
      pv = bus.result_valid;
      pr = bus.result;
    end
  end

  initial begin
    bus.start = 0; bus.cont = 0; bus.filt_data = '0; bus.filt_new_data = 0; bus.result_ready = 0;
    rst = 1'b1;
    step(3);
    chk_reset_vals("por");
    rst = 1'b0;
    step(1);

    // Single shot, strobe at E0+517.
    do_start();
    chk("ss_busy_e0", bus.busy, 1);
    chk("ss_frn_e0", bus.filt_rst_n, 0);
    chk("ss_modrst_e0", bus.mod_rst, 1);
    step(1);
    chk("ss_frn_e1", bus.filt_rst_n, 0);
    step(1);
    chk("ss_frn_e2", bus.filt_rst_n, 1);
    chk("ss_modrst_e2", bus.mod_rst, 0);
    step(514);
    chk("ss_frn_e516", bus.filt_rst_n, 1);
    chk("ss_valid_e516", bus.result_valid, 0);
    chk("ss_busy_e516", bus.busy, 1);
    strobe(12'h5A3, 1'b0);
    chk("ss_valid_e517", bus.result_valid, 1);
    chk("ss_busy_e517", bus.busy, 0);
    chk("ss_frn_e517", bus.filt_rst_n, 0);
    chk("ss_overrun", bus.overrun, 0);
    ack();
    chk("ss_valid_after_ack", bus.result_valid, 0);

    // Minimum latency capture (E0+515), then capture coinciding with a handshake.
    do_start();
    step(514);
    chk("ml_valid_e514", bus.result_valid, 0);
    strobe(12'h0AA, 1'b0);
    chk("ml_valid_e515", bus.result_valid, 1);
    do_start();
    step(514);
    strobe(12'h0AB, 1'b1);
    chk("hs_valid", bus.result_valid, 1);
    chk("hs_result", bus.result, 12'h0AB);
    chk("hs_overrun", bus.overrun, 0);

    // Capture over an unconsumed result sets overrun.
    do_start();
    step(516);
    strobe(12'h3C5, 1'b0);
    chk("ov_overrun", bus.overrun, 1);
    chk("ov_valid", bus.result_valid, 1);
    ack();
    chk("ov_valid_after_ack", bus.result_valid, 0);

    // Timeout; a stray strobe during CONVERT must be ignored.
    do_start();
    step(200);
    bus.filt_data = 12'h7FF; bus.filt_new_data = 1'b1;
    step(1);
    bus.filt_new_data = 1'b0;
    step(320);
    chk("to_flag_e521", bus.timeout, 0);
    chk("to_busy_e521", bus.busy, 1);
    step(1);
    chk("to_flag_e522", bus.timeout, 1);
    chk("to_busy_e522", bus.busy, 0);
    chk("to_valid", bus.result_valid, 0);
    chk("to_frn", bus.filt_rst_n, 0);

    // start during CONVERT does not stretch the conversion.
    do_start();
    step(100);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(420);
    chk("si_busy_e521", bus.busy, 1);
    chk("si_frn_e521", bus.filt_rst_n, 1);
    step(1);
    chk("si_busy_e522", bus.busy, 0);

    // Reset mid-CONVERT.
    do_start();
    step(10);
    rst = 1'b1;
    step(1);
    chk_reset_vals("mid");
    step(2);
    rst = 1'b0;
    step(1);

`ifdef IADC_SEQ_CONTINUOUS_EN
    bus.cont = 1'b1;
    do_start();
    step(516);
    strobe(12'h111, 1'b0);
    chk("ct_busy_c0", bus.busy, 1);
    chk("ct_frn_c0", bus.filt_rst_n, 0);
    step(1);
    chk("ct_frn_c1", bus.filt_rst_n, 0);
    step(1);
    chk("ct_frn_c2", bus.filt_rst_n, 1);
    bus.cont = 1'b0;
    step(512);
    strobe(12'h222, 1'b0);
    chk("ct_overrun", bus.overrun, 1);
    chk("ct_result", bus.result, 12'h222);
    chk("ct_busy_end", bus.busy, 0);
    ack();
`endif

    step(2);
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/iadc_conv_sequencer.md
# iadc_conv_sequencer

Conversion sequencer for the incremental ADC. It owns the reset/convert cycle of the delta-sigma modulator and the `digital_filter` decimator:
- holds both in reset between conversions;
- releases them for exactly OSR modulator clocks;
- waits for the filter's `new_data` strobe and captures the 12-bit result into a valid/ready output register.

It sits between the host/readout logic and the filter. Single-shot by default, with optional back-to-back continuous conversion.

## Interface
- `OSR`, 512, modulator samples per conversion (≥ 2)
- `RST_CYCLES`, 2, cycles filter/modulator held in reset before each conversion (≥ 1)
- `TIMEOUT`, 8, max cycles to wait for `filt_new_data` after OSR samples (≥ 1)
- `DW`, 12, result width
- `clk`  in  1  conversion clock (same clock as `digital_filter`)
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  conversion request, sampled each cycle
- `cont`  in  1  continuous-mode request (only with `IADC_SEQ_CONTINUOUS_EN`)
- `filt_rst_n`  out  1  active-low reset to `digital_filter`
- `mod_rst`  out  1  active-high reset to modulator integrators
- `filt_data`  in  DW  filter `data_out`
- `filt_new_data`  in  1  filter `new_data`
- `result`  out  DW  captured conversion result
- `result_valid`  out  1  result available
- `result_ready`  in  1  consumer accepts result
- `busy`  out  1  conversion in progress
- `overrun`  out  1  sticky: unconsumed result overwritten
- `timeout`  out  1  sticky: filter failed to strobe `new_data`

## Operation
- States: IDLE, RESET, CONVERT, WAIT.
- **IDLE**
  - Outputs: `filt_rst_n`=0, `mod_rst`=1, `busy`=0.
  - `start`=1 → RESET; counter loads `RST_CYCLES`-1.
- **RESET**
  - Outputs: `filt_rst_n`=0, `mod_rst`=1, `busy`=1.
  - Counts down; at 0 → CONVERT, counter loads `OSR`-1.
- **CONVERT**
  - Outputs: `filt_rst_n`=1, `mod_rst`=0, `busy`=1.
  - Counts down; at 0 → WAIT, counter loads `TIMEOUT`-1.
- **WAIT**
  - Outputs: `filt_rst_n`=1, `mod_rst`=0, `busy`=1.
  - `filt_new_data`=1 → `result`←`filt_data`, `result_valid`←1, next state is IDLE. With continuous mode active it is RESET instead.
  - Counter 0 with no strobe → `timeout`←1, → IDLE; `result` and `result_valid` are unchanged.
- `filt_new_data` is ignored outside WAIT.
- `start` is ignored unless the state is IDLE.
- Counter width: `$clog2(max(OSR, RST_CYCLES, TIMEOUT))`. It is a single shared down-counter; there is no wrap-around.
- **Output register**
  - `result_valid && result_ready` → `result_valid`←0.
  - Capture while `result_valid`=1 and `result_ready`=0 → `result` overwritten, `result_valid` stays 1, `overrun`←1.
  - Capture in the same cycle as a handshake → new value loaded, `result_valid` stays 1, no overrun.
- `overrun` and `timeout` clear only on `rst`.
- **Reset values:**
  - State IDLE.
  - `filt_rst_n`=0, `mod_rst`=1.
  - `result`=0, `result_valid`=0.
  - `busy`=0, `overrun`=0, `timeout`=0.
- `rst` asserted mid-conversion: reset values take effect at the next edge. The filter is therefore back in reset one cycle later.

## Timing
- All outputs are registered.
- `start` sampled at edge E0:
  - `busy`=1 and RESET after E0.
  - CONVERT after E0+`RST_CYCLES`; `filt_rst_n` rises here.
  - WAIT after E0+`RST_CYCLES`+`OSR`.
- `filt_new_data` sampled high at edge Ek in WAIT → `result_valid`=1 and `busy`=0 after Ek (single-shot).
- Minimum start-to-valid latency: `RST_CYCLES`+`OSR`+1 cycles.
- Timeout flag sets after E0+`RST_CYCLES`+`OSR`+`TIMEOUT`.
- Continuous mode: conversions are separated by exactly `RST_CYCLES` reset cycles.

## Configuration
- Macro: `IADC_SEQ_CONTINUOUS_EN`.
- **Defined:** after a successful capture in WAIT, `cont`=1 → RESET (next conversion starts immediately, `busy` stays 1); `cont`=0 → IDLE.
- **Undefined:** `cont` is unused; every conversion is single-shot and returns to IDLE.
- **Both builds:** timeout always returns to IDLE.

## Test plan
Parameters for all scenarios: `OSR`=512, `RST_CYCLES`=2, `TIMEOUT`=8.
1. Assert `rst` for 3 cycles mid-CONVERT → next edge: `filt_rst_n`=0, `mod_rst`=1, `busy`=0, `result`=0, flags 0.
2. Single shot: `start` at E0; filter model drives `filt_data`=0x5A3 with `filt_new_data` sampled at E0+517 → `filt_rst_n` high E0+2..E0+517, `result`=0x5A3, `result_valid`=1 after E0+517. `result_ready` pulse → `result_valid`=0 next cycle.
3. Timeout: `start` at E0, `filt_new_data` never asserted → `timeout`=1 and `busy`=0 after E0+522, `result_valid` stays 0.
4. With `IADC_SEQ_CONTINUOUS_EN`, `cont`=1, `result_ready`=0: two captures 0x111 then 0x222 → `overrun`=1, `result`=0x222, and exactly 2 reset cycles between conversions.
5. `start` pulsed during CONVERT → ignored, conversion length unchanged (512 `filt_rst_n`-high cycles before WAIT).
6. Capture 0x0AB in the same cycle as a `result_ready` handshake on a pending 0x0AA → `result`=0x0AB, `result_valid`=1, `overrun`=0.
